// File: rtl/multi_timer_pkg.sv
// Shared definitions for multi_timer: channel mode encodings and channel-index width helper.
package multi_timer_pkg;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   function automatic int ch_idx_w(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One down-counting timer channel: period/mode registers, start/stop control and expiry pulse.
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_Tick,
   input  logic             i_Cfg_Wr,
   input  logic [CNT_W-1:0] i_Cfg_Period,
   input  logic             i_Cfg_Mode,
   input  logic             i_Start,
   input  logic             i_Stop,
   output logic             o_Trigger,
   output logic             o_Running
);

   logic [CNT_W-1:0] r_period;
   logic             r_mode;
   logic [CNT_W-1:0] r_cnt;
   logic             r_running;
   logic             r_trigger;
   logic [CNT_W-1:0] w_start_period;

   // A start in the same cycle as a config write uses the period being written.
   always_comb begin
      w_start_period = r_period;
      if (i_Cfg_Wr) begin
         w_start_period = i_Cfg_Period;
      end else begin
         w_start_period = r_period;
      end
   end

   // Config registers, counter, run flag and registered trigger pulse.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_period  <= {CNT_W{1'b0}};
         r_mode    <= MODE_PERIODIC;
         r_cnt     <= {CNT_W{1'b0}};
         r_running <= 1'b0;
         r_trigger <= 1'b0;
      end else begin
         r_trigger <= 1'b0;
         if (i_Cfg_Wr) begin
            r_period <= i_Cfg_Period;
            r_mode   <= i_Cfg_Mode;
         end
         if (i_Stop) begin
            r_running <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
         end else if (i_Start && (w_start_period != {CNT_W{1'b0}})) begin
            r_cnt     <= w_start_period - {{(CNT_W-1){1'b0}}, 1'b1};
            r_running <= 1'b1;
         end else if (r_running && i_Tick) begin
            if (r_cnt == {CNT_W{1'b0}}) begin
               r_trigger <= 1'b1;
               // A period rewritten to zero mid-count cannot be reloaded, so it ends the run.
               if ((r_mode == MODE_ONESHOT) || (r_period == {CNT_W{1'b0}})) begin
                  r_running <= 1'b0;
               end else begin
                  r_cnt <= r_period - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end else begin
               r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign o_Trigger = r_trigger;
   assign o_Running = r_running;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent programmable timers with config decode and an optional shared prescaler
// enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter int PRESCALE = 1
)(
   input  logic                          i_Clk,
   input  logic                          i_Rst_L,
   input  logic                          i_Cfg_Wr,
   input  logic [ch_idx_w(NUM_CH)-1:0]   i_Cfg_Ch,
   input  logic [CNT_W-1:0]              i_Cfg_Period,
   input  logic                          i_Cfg_Mode,
   input  logic [NUM_CH-1:0]             i_Start,
   input  logic [NUM_CH-1:0]             i_Stop,
   output logic [NUM_CH-1:0]             o_Trigger,
   output logic [NUM_CH-1:0]             o_Running
);

   localparam int CH_IDX_W = ch_idx_w(NUM_CH);

   logic w_tick;

   if (PRESCALE < 1) begin : g_prescale_range
      $error("multi_timer: PRESCALE must be >= 1");
   end

`ifdef MULTI_TIMER_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] r_ps_cnt;

   // Free-running prescaler; only the hard reset restarts its phase.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_ps_cnt <= {PS_W{1'b0}};
      end else if (r_ps_cnt == PS_LAST) begin
         r_ps_cnt <= {PS_W{1'b0}};
      end else begin
         r_ps_cnt <= r_ps_cnt + {{(PS_W-1){1'b0}}, 1'b1};
      end
   end

   assign w_tick = (r_ps_cnt == PS_LAST);
`else
   assign w_tick = 1'b1;
`endif

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      localparam logic [CH_IDX_W-1:0] LP_IDX = CH_IDX_W'(n);
      logic w_cfg_wr;

      // Indices with no matching channel select nothing and are dropped.
      assign w_cfg_wr = i_Cfg_Wr && (i_Cfg_Ch == LP_IDX);

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .i_Clk        (i_Clk),
         .i_Rst_L      (i_Rst_L),
         .i_Tick       (w_tick),
         .i_Cfg_Wr     (w_cfg_wr),
         .i_Cfg_Period (i_Cfg_Period),
         .i_Cfg_Mode   (i_Cfg_Mode),
         .i_Start      (i_Start[n]),
         .i_Stop       (i_Stop[n]),
         .o_Trigger    (o_Trigger[n]),
         .o_Running    (o_Running[n])
      );
   end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor to the single fixed-period timer: NUM_CH independent down-counting channels, each with a runtime-programmable period and mode (periodic or one-shot).
- Per-channel start/stop control and single-cycle trigger pulses.
- Sits beside the system clock and feeds LED blinkers, debouncers and UART/VGA pacing logic that previously each instantiated their own fixed timer.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, counter and period width in bits.
- PRESCALE, 1, clock cycles per channel tick; used only with MULTI_TIMER_PRESCALE_EN (>=1).

Ports:
- i_Clk  input  1  system clock; all logic on the rising edge.
- i_Rst_L  input  1  synchronous, active-low reset.
- i_Cfg_Wr  input  1  write strobe for the period/mode of channel i_Cfg_Ch.
- i_Cfg_Ch  input  CH_IDX_W  channel index for the config write; CH_IDX_W = max(1, clog2(NUM_CH)).
- i_Cfg_Period  input  CNT_W  period in ticks.
- i_Cfg_Mode  input  1  0 = periodic, 1 = one-shot.
- i_Start  input  NUM_CH  per-channel start/restart strobe.
- i_Stop  input  NUM_CH  per-channel stop strobe.
- o_Trigger  output  NUM_CH  one-cycle pulse per expiry.
- o_Running  output  NUM_CH  channel is counting.

Behaviour:
- Reset (i_Rst_L low at an edge):
  - All periods = 0, all modes = periodic, all counters = 0.
  - o_Trigger = 0 and o_Running = 0.
  - Reset mid-count aborts with no trigger.
- Config write:
  - i_Cfg_Wr at edge k updates channel i_Cfg_Ch's period and mode registers.
  - An index >= NUM_CH is ignored.
  - A write to a running channel does not disturb the current count. The new period takes effect at the next reload or start.
- Start (i_Start[n] at edge k, period P >= 1):
  - counter <= P-1 and o_Running[n] <= 1.
  - A start while running restarts from P-1.
  - A start with P = 0 is ignored; the channel stays idle.
  - A config write and a start to the same channel in the same cycle: the start uses the newly written period.
- Counting: each tick, a running counter > 0 decrements.
- Expiry (running counter == 0 on a tick):
  - o_Trigger[n] = 1 for exactly one cycle after that edge.
  - Periodic mode: counter reloads with the current period - 1 and the channel keeps running.
  - One-shot mode: o_Running[n] <= 0 on the same edge.
- Latency: with a start at edge k and a tick every cycle, the first trigger is high after edge k+P, then every P cycles. So the period is exactly P cycles, with no +1 error. P = 1 gives a continuous trigger.
- Stop: i_Stop[n] clears o_Running[n] and the counter, and suppresses any trigger due that edge. If i_Stop and i_Start are both set on the same channel, stop wins.
- Arithmetic: unsigned CNT_W; no wrap below 0, because reload occurs at 0.
- Channel independence: channels are fully independent; simultaneous triggers on several channels are all reported.

Optional Feature:
- Macro: MULTI_TIMER_PRESCALE_EN.
- Defined:
  - A shared free-running prescaler counts 0..PRESCALE-1 and emits a one-cycle tick at PRESCALE-1.
  - Channels decrement and expire only on ticks. The first expiry after a start therefore occurs within (P-1)*PRESCALE+1 .. P*PRESCALE cycles.
  - The prescaler resets with i_Rst_L only.
- Undefined: tick is constant 1; PRESCALE is ignored; no prescaler logic is synthesised.

Decomposition:
- Package multi_timer_pkg holds:
  - MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1.
  - The CH_IDX_W computation function.
- Sub-module timer_channel: one counter, period/mode registers, and start/stop/expiry logic. It is instantiated NUM_CH times via generate. The top level holds config decode and the optional prescaler.

Test Plan:
- Reset then idle 100 cycles -> o_Trigger = 0, o_Running = 0 throughout.
- Ch0 period 5, periodic, start at edge 10 -> triggers after edges 15, 20, 25; o_Running[0] stays 1.
- Ch1 period 3, one-shot, start -> single trigger 3 cycles later; o_Running[1] drops on the same edge; no further pulses.
- Ch2 period 4 running; write period 7 mid-count -> next trigger still 4 after the previous one, then spacing 7. Start with period 0 -> ignored.
- Stop + start on ch3 in the same cycle -> ch3 idle. Stop on the expiry edge -> no trigger. Reset asserted mid-count -> no trigger, all outputs 0.
- With MULTI_TIMER_PRESCALE_EN and PRESCALE = 4: ch0 period 2, periodic -> trigger spacing 8 cycles. First trigger 5..8 cycles after the start, depending on prescaler phase.
